// File: rtl/msu_stream.sv
// rtl/msu_stream.sv - squaring job sequencer: receive seed, drive squarer, stream checkpoint/final frames
module msu_stream #(
  parameter int AXI_LEN               = 64,
  parameter int C_XFER_SIZE_WIDTH     = 32,
  parameter int REDUNDANT_ELEMENTS    = 2,
  parameter int NONREDUNDANT_ELEMENTS = 8,
  parameter int NUM_ELEMENTS          = NONREDUNDANT_ELEMENTS + REDUNDANT_ELEMENTS,
  parameter int BIT_LEN               = 17,
  parameter int WORD_LEN              = 16,
  parameter int T_LEN                 = 64
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     s_axis_tvalid,
  output logic                                     s_axis_tready,
  input  logic [AXI_LEN-1:0]                       s_axis_tdata,
  output logic [C_XFER_SIZE_WIDTH-1:0]             s_axis_xfer_size_in_bytes,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic [AXI_LEN-1:0]                       m_axis_tdata,
  output logic [AXI_LEN/8-1:0]                     m_axis_tkeep,
  output logic                                     m_axis_tlast,
  output logic                                     m_axis_tuser,
  output logic [C_XFER_SIZE_WIDTH-1:0]             m_axis_xfer_size_in_bytes,
  input  logic [T_LEN-1:0]                         ckpt_interval,
  input  logic                                     abort,
  output logic                                     sq_start,
  output logic                                     sq_rst,
  output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]     sq_in,
  input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]     sq_out,
  input  logic                                     sq_valid,
  output logic                                     ap_done,
  output logic                                     start_xfer,
  output logic                                     ckpt_overflow
);

  localparam int TB        = T_LEN / AXI_LEN;
  localparam int EIN       = AXI_LEN / WORD_LEN;
  localparam int EOUT      = AXI_LEN / 32;
  localparam int IN_BEATS  = 2 * TB + (NONREDUNDANT_ELEMENTS + EIN - 1) / EIN;
  localparam int OUT_BEATS = TB + (NUM_ELEMENTS + EOUT - 1) / EOUT;
  localparam int IB_W      = $clog2(IN_BEATS);
  localparam int OB_W      = $clog2(OUT_BEATS);

  typedef enum logic [2:0] {RECV, LOAD, START, COMPUTE, DRAIN, SEND, DONE} state_t;
  typedef logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] elems_t;

  logic [1:0]         rst_sync_q;
  logic               rst_n_int;
  state_t             state_q;
  logic [IB_W-1:0]    in_cnt_q;
  logic [AXI_LEN-1:0] in_buf_q [IN_BEATS];
  logic [T_LEN-1:0]   t_cur_q, ckpt_int_q, ckpt_cnt_q, out_t_q;
  elems_t             sq_in_q, out_el_q;
  logic               out_valid_q, out_final_q;
  logic [OB_W-1:0]    beat_q;
  logic               sq_start_q, ap_done_q, start_xfer_q, ovf_q;
  logic [T_LEN-1:0]   t_start, t_final, t_next;
  elems_t             seed;
  logic               ckpt_due, out_last, out_fire;
  logic [AXI_LEN-1:0] beat_data;

  // Assertion is immediate through the async clear; release reaches the core two edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  always_comb begin
    t_start = '0;
    t_final = '0;
    seed    = '0;
    for (int b = 0; b < TB; b++) begin
      t_start[b*AXI_LEN +: AXI_LEN] = in_buf_q[b];
      t_final[b*AXI_LEN +: AXI_LEN] = in_buf_q[TB+b];
    end
    for (int k = 0; k < NONREDUNDANT_ELEMENTS; k++)
      seed[k] = BIT_LEN'(in_buf_q[2*TB + k/EIN][WORD_LEN*(k%EIN) +: WORD_LEN]);
  end

  always_comb begin
    beat_data = '0;
    for (int b = 0; b < TB; b++)
      if (beat_q == OB_W'(b)) beat_data = out_t_q[b*AXI_LEN +: AXI_LEN];
    for (int k = 0; k < NUM_ELEMENTS; k++)
      if (beat_q == OB_W'(TB + k/EOUT)) beat_data[32*(k%EOUT) +: 32] = 32'(out_el_q[k]);
  end

  assign t_next   = t_cur_q + T_LEN'(1);
  assign ckpt_due = (ckpt_int_q != '0) && (ckpt_cnt_q + T_LEN'(1) == ckpt_int_q);
  assign out_last = (beat_q == OB_W'(OUT_BEATS-1));
  assign out_fire = out_valid_q && m_axis_tready;

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q      <= RECV;
      in_cnt_q     <= '0;
      for (int i = 0; i < IN_BEATS; i++) in_buf_q[i] <= '0;
      t_cur_q      <= '0;
      ckpt_int_q   <= '0;
      ckpt_cnt_q   <= '0;
      out_t_q      <= '0;
      sq_in_q      <= '0;
      out_el_q     <= '0;
      out_valid_q  <= 1'b0;
      out_final_q  <= 1'b0;
      beat_q       <= '0;
      sq_start_q   <= 1'b0;
      ap_done_q    <= 1'b0;
      start_xfer_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      sq_start_q   <= 1'b0;
      ap_done_q    <= 1'b0;
      start_xfer_q <= 1'b0;
      if (out_fire) begin
        if (out_last) begin
          out_valid_q <= 1'b0;
          beat_q      <= '0;
        end else begin
          beat_q <= beat_q + OB_W'(1);
        end
      end
      if (abort && state_q != RECV) begin
        state_q     <= RECV;
        out_valid_q <= 1'b0;
        beat_q      <= '0;
        in_cnt_q    <= '0;
      end else begin
        case (state_q)
          RECV: if (s_axis_tvalid) begin
            in_buf_q[in_cnt_q] <= s_axis_tdata;
            if (in_cnt_q == IB_W'(IN_BEATS-1)) begin
              in_cnt_q <= '0;
              state_q  <= LOAD;
            end else begin
              in_cnt_q <= in_cnt_q + IB_W'(1);
            end
          end
          LOAD: begin
            sq_in_q    <= seed;
            t_cur_q    <= t_start;
            ckpt_int_q <= ckpt_interval;
            ckpt_cnt_q <= '0;
            ovf_q      <= 1'b0;
            state_q    <= START;
          end
          START: if (t_start == t_final) begin
            out_t_q      <= t_final;
            out_el_q     <= sq_in_q;
            out_final_q  <= 1'b1;
            out_valid_q  <= 1'b1;
            beat_q       <= '0;
            start_xfer_q <= 1'b1;
            state_q      <= SEND;
          end else begin
            sq_start_q <= 1'b1;
            state_q    <= COMPUTE;
          end
          COMPUTE: if (sq_valid) begin
            t_cur_q <= t_next;
            if (t_next == t_final) begin
              // sq_in_q parks the final result while an earlier checkpoint drains
              sq_in_q <= sq_out;
              if (out_valid_q) begin
                state_q <= DRAIN;
              end else begin
                out_t_q      <= t_next;
                out_el_q     <= sq_out;
                out_final_q  <= 1'b1;
                out_valid_q  <= 1'b1;
                beat_q       <= '0;
                start_xfer_q <= 1'b1;
                state_q      <= SEND;
              end
            end else if (ckpt_due) begin
              ckpt_cnt_q <= '0;
              if (out_valid_q) begin
                ovf_q <= 1'b1;
              end else begin
                out_t_q     <= t_next;
                out_el_q    <= sq_out;
                out_final_q <= 1'b0;
                out_valid_q <= 1'b1;
                beat_q      <= '0;
              end
            end else begin
              ckpt_cnt_q <= ckpt_cnt_q + T_LEN'(1);
            end
          end
          DRAIN: if (!out_valid_q) begin
            out_t_q      <= t_final;
            out_el_q     <= sq_in_q;
            out_final_q  <= 1'b1;
            out_valid_q  <= 1'b1;
            beat_q       <= '0;
            start_xfer_q <= 1'b1;
            state_q      <= SEND;
          end
          SEND: if (out_fire && out_last) begin
            ap_done_q <= 1'b1;
            state_q   <= DONE;
          end
          DONE:    state_q <= RECV;
          default: state_q <= RECV;
        endcase
      end
    end
  end

  assign s_axis_tready             = rst_n_int && (state_q == RECV);
  assign s_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(IN_BEATS * AXI_LEN / 8);
  assign m_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(OUT_BEATS * AXI_LEN / 8);
  assign m_axis_tvalid             = out_valid_q;
  assign m_axis_tdata              = beat_data;
  assign m_axis_tkeep              = '1;
  assign m_axis_tlast              = out_valid_q && out_last;
  assign m_axis_tuser              = out_final_q;
  assign sq_start                  = sq_start_q;
  assign sq_rst                    = !rst_n_int || (state_q == RECV) || (state_q == DONE);
  assign sq_in                     = sq_in_q;
  assign ap_done                   = ap_done_q;
  assign start_xfer                = start_xfer_q;
  assign ckpt_overflow             = ovf_q;

endmodule

// File: tb/tb_msu_stream.sv
// tb/tb_msu_stream.sv - randomized bench for msu_stream against a frame-level reference model
module tb_msu_stream;
  localparam int NUM = 10, NR = 8, BL = 17, OUTB = 6;

  typedef struct packed {logic [63:0] data; logic last; logic user;} beat_t;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  logic                     s_axis_tvalid = 1'b0, s_axis_tready;
  logic [63:0]              s_axis_tdata = '0;
  logic [31:0]              s_xfer, m_xfer;
  logic                     m_axis_tvalid, m_axis_tready = 1'b0;
  logic [63:0]              m_axis_tdata;
  logic [7:0]               m_axis_tkeep;
  logic                     m_axis_tlast, m_axis_tuser;
  logic [63:0]              ckpt_interval = '0;
  logic                     abort = 1'b0;
  logic                     sq_start, sq_rst, sq_valid = 1'b0;
  logic [NUM-1:0][BL-1:0]   sq_in, sq_out = '0;
  logic                     ap_done, start_xfer, ckpt_overflow;

  msu_stream dut (
    .clk(clk), .reset_n(reset_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_xfer_size_in_bytes(s_xfer),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_xfer_size_in_bytes(m_xfer),
    .ckpt_interval(ckpt_interval), .abort(abort),
    .sq_start(sq_start), .sq_rst(sq_rst), .sq_in(sq_in), .sq_out(sq_out), .sq_valid(sq_valid),
    .ap_done(ap_done), .start_xfer(start_xfer), .ckpt_overflow(ckpt_overflow)
  );

  int vectors = 0, miscompares = 0;
  logic [15:0] words [NR];
  logic [16:0] vals [NUM];
  logic [16:0] seed_m [NUM];
  logic [63:0] t_cur_m, t_final_m, interval_m, cnt_m;
  bit          ovf_m;
  int          sq_rem = 0, sq_tmr = 0, sq_per = 1;
  beat_t       exp_q [$];
  logic [63:0] in_q [$];
  logic [63:0] rx_t [$];
  logic [63:0] rx [OUTB];
  int          rx_idx = 0, mode = 0, lowc = 0;
  bit          prev_stall = 0, prev_user = 0;
  logic [63:0] prev_data = '0;
  int          ap_done_cnt = 0, sq_start_cnt = 0;
  bit          do_abort = 0, just_aborted = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] rxt(int i);
    return (i < rx_t.size()) ? rx_t[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  // Expected frame: t in beat 0, then two 32-bit element slots per beat, zero-extended.
  function automatic void push_frame(logic [63:0] t, bit fin);
    beat_t x;
    for (int b = 0; b < OUTB; b++) begin
      if (b == 0) x.data = t;
      else begin
        x.data = '0;
        for (int j = 0; j < 2; j++)
          if (2*(b-1)+j < NUM) x.data[32*j +: 32] = {15'd0, vals[2*(b-1)+j]};
      end
      x.last = (b == OUTB-1);
      x.user = fin;
      exp_q.push_back(x);
    end
  endfunction

  function automatic void squarer_valid();
    logic [33:0] p;
    for (int k = 0; k < NUM; k++) begin
      p = {17'd0, vals[k]} * {17'd0, vals[k]};
      vals[k] = p[16:0] + 17'd3;
      sq_out[k] = vals[k];
    end
    t_cur_m = t_cur_m + 64'd1;
    if (t_cur_m == t_final_m) push_frame(t_cur_m, 1'b1);
    else if (interval_m != 0 && cnt_m + 64'd1 == interval_m) begin
      cnt_m = 0;
      if (m_axis_tvalid) ovf_m = 1'b1;
      else push_frame(t_cur_m, 1'b0);
    end else cnt_m = cnt_m + 64'd1;
  endfunction

  task automatic step();
    bit r;
    beat_t e;
    @(negedge clk);
    if (just_aborted) begin
      chk("abort_sq_rst", sq_rst, 1);
      chk("abort_tvalid", m_axis_tvalid, 0);
      just_aborted = 0;
    end
    if (prev_stall) begin
      chk("hold_tvalid", m_axis_tvalid, 1);
      chk("hold_tdata", m_axis_tdata, prev_data);
      chk("hold_tuser", m_axis_tuser, prev_user);
    end
    if (ap_done) ap_done_cnt++;
    sq_valid = 1'b0;
    if (sq_rem > 0) begin
      sq_tmr--;
      if (sq_tmr == 0) begin
        sq_tmr = sq_per;
        sq_rem--;
        sq_valid = 1'b1;
        squarer_valid();
      end
    end
    if (sq_start) begin
      sq_start_cnt++;
      for (int k = 0; k < NUM; k++) chk($sformatf("sq_in_seed%0d", k), sq_in[k], seed_m[k]);
      sq_rem = int'(t_final_m - t_cur_m);
      sq_tmr = sq_per;
    end
    abort = do_abort;
    if (mode == 0) r = 1'b1;
    else if (mode == 1) r = ($urandom_range(0, 3) != 0);
    else begin
      r = (lowc == 0);
      if (lowc > 0) lowc--;
    end
    if (do_abort) r = 1'b0;
    m_axis_tready = r;
    if (m_axis_tvalid && r) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got 0x%0h, expected no beat", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        chk("beat_tdata", m_axis_tdata, e.data);
        chk("beat_tlast", m_axis_tlast, e.last);
        chk("beat_tuser", m_axis_tuser, e.user);
      end
      if (rx_idx == 0) rx_t.push_back(m_axis_tdata);
      rx[rx_idx] = m_axis_tdata;
      rx_idx = (m_axis_tlast || rx_idx == OUTB-1) ? 0 : rx_idx + 1;
    end
    prev_stall = m_axis_tvalid && !r && !do_abort;
    prev_data  = m_axis_tdata;
    prev_user  = m_axis_tuser;
    if (in_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = in_q[0];
      if (s_axis_tready) void'(in_q.pop_front());
    end else s_axis_tvalid = 1'b0;
    if (do_abort) begin
      exp_q.delete();
      in_q.delete();
      sq_rem = 0;
      rx_idx = 0;
      do_abort = 0;
      just_aborted = 1;
    end
  endtask

  task automatic setup_job(logic [63:0] ts, logic [63:0] tf, logic [63:0] iv, int per, int md, int lc);
    for (int k = 0; k < NUM; k++) begin
      seed_m[k] = (k < NR) ? {1'b0, words[k]} : 17'd0;
      vals[k]   = seed_m[k];
    end
    t_cur_m = ts; t_final_m = tf; interval_m = iv; cnt_m = 0; ovf_m = 0;
    sq_per = per; mode = md; lowc = lc; rx_t.delete(); rx_idx = 0;
    ckpt_interval = iv;
    in_q.push_back(ts);
    in_q.push_back(tf);
    in_q.push_back({words[3], words[2], words[1], words[0]});
    in_q.push_back({words[7], words[6], words[5], words[4]});
    if (ts == tf) push_frame(tf, 1'b1);
  endtask

  task automatic run_job(logic [63:0] ts, logic [63:0] tf, logic [63:0] iv, int per, int md, int lc, int abort_at);
    int d0, s0;
    d0 = ap_done_cnt;
    s0 = sq_start_cnt;
    setup_job(ts, tf, iv, per, md, lc);
    if (abort_at > 0) begin
      repeat (abort_at) step();
      do_abort = 1;
      step();
      repeat (30) step();
      chk("abort_no_ap_done", ap_done_cnt - d0, 0);
      chk("abort_sq_started", sq_start_cnt - s0, 1);
      return;
    end
    for (int i = 0; i < 5000 && ap_done_cnt == d0; i++) step();
    if (ap_done_cnt == d0) chk("job_done_timeout", 0, 1);
    repeat (4) step();
    chk("ap_done_pulses", ap_done_cnt - d0, 1);
    chk("sq_start_pulses", sq_start_cnt - s0, (ts != tf) ? 1 : 0);
    chk("frames_left", exp_q.size(), 0);
    chk("ckpt_overflow", ckpt_overflow, ovf_m);
  endtask

  task automatic rand_words();
    for (int k = 0; k < NR; k++) words[k] = 16'($urandom);
  endtask

  initial begin
    #12;
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tuser", m_axis_tuser, 0);
    chk("rst_sq_start", sq_start, 0);
    chk("rst_ap_done", ap_done, 0);
    chk("rst_start_xfer", start_xfer, 0);
    chk("rst_ovf", ckpt_overflow, 0);
    chk("rst_sq_rst", sq_rst, 1);
    chk("tkeep", m_axis_tkeep, 8'hFF);
    chk("s_xfer_size", s_xfer, 32);
    chk("m_xfer_size", m_xfer, 48);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();
    chk("tready_after_reset", s_axis_tready, 1);

    rand_words();
    run_job(64'd0, 64'd5, 64'd0, 8, 0, 0, 0);
    chk("r20_frames", rx_t.size(), 1);
    chk("r20_t", rxt(0), 64'd5);

    for (int k = 0; k < NR; k++) words[k] = 16'h1111 * 16'(k + 1);
    run_job(64'd7, 64'd7, 64'd0, 8, 0, 0, 0);
    chk("r21_t", rx[0], 64'd7);
    chk("r21_beat1", rx[1], 64'h0000_2222_0000_1111);
    chk("r21_beat4", rx[4], 64'h0000_8888_0000_7777);
    chk("r21_beat5", rx[5], 64'h0);

    rand_words();
    run_job(64'd0, 64'd10, 64'd3, 8, 0, 0, 0);
    chk("r22_frames", rx_t.size(), 4);
    chk("r22_t0", rxt(0), 64'd3);
    chk("r22_t1", rxt(1), 64'd6);
    chk("r22_t2", rxt(2), 64'd9);
    chk("r22_t3", rxt(3), 64'd10);
    chk("r22_ovf", ckpt_overflow, 0);

    rand_words();
    run_job(64'd0, 64'd20, 64'd1, 4, 2, 40, 0);
    chk("r23_ovf", ckpt_overflow, 1);
    chk("r23_final_t", rxt(rx_t.size() - 1), 64'd20);

    rand_words();
    run_job(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'd2, 3, 1, 0, 0);
    chk("wrap_final_t", rxt(rx_t.size() - 1), 64'd3);

    for (int j = 0; j < 8; j++) begin
      logic [63:0] ts;
      ts = {$urandom, $urandom};
      rand_words();
      run_job(ts, ts + 64'($urandom_range(0, 25)), 64'($urandom_range(0, 5)),
              $urandom_range(1, 10), 1, 0, 0);
    end

    rand_words();
    run_job(64'd0, 64'd30, 64'd2, 5, 1, 0, 40);
    rand_words();
    run_job(64'd100, 64'd112, 64'd4, 3, 0, 0, 0);
    chk("post_abort_final_t", rxt(rx_t.size() - 1), 64'd112);

    rand_words();
    setup_job(64'd0, 64'd4, 64'd0, 2, 2, 100000);
    for (int i = 0; i < 300 && !m_axis_tvalid; i++) step();
    chk("send_reached", m_axis_tvalid, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tready", s_axis_tready, 0);
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_tlast", m_axis_tlast, 0);
    chk("mid_rst_tuser", m_axis_tuser, 0);
    chk("mid_rst_sq_start", sq_start, 0);
    chk("mid_rst_ap_done", ap_done, 0);
    chk("mid_rst_start_xfer", start_xfer, 0);
    chk("mid_rst_ovf", ckpt_overflow, 0);
    chk("mid_rst_sq_rst", sq_rst, 1);
    exp_q.delete();
    in_q.delete();
    sq_rem = 0;
    rx_idx = 0;
    prev_stall = 0;
    mode = 0;
    lowc = 0;
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("mid_rst_tready_back", s_axis_tready, 1);
    repeat (20) step();
    rand_words();
    run_job(64'd50, 64'd57, 64'd3, 2, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
